// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the sync bundle carried through the output delay line.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic logic in_window(logic [9:0] val, logic [9:0] lo, logic [9:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Clock-enabled shift register for the sync bundle; every stage resets to the idle levels.
module sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  sync_t d,
    output sync_t q
);

    sync_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan counters, delayed sync/blank outputs and per-frame strobes, one pixel every two Clk.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_DLY = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_en,
    output logic       frame_start,
    output logic       vblank_start
);

    localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // A zero-depth request still gets one register so outputs never come straight from compare logic.
    localparam int STAGES      = (PIPE_DLY < 1) ? 1 : PIPE_DLY;

    localparam logic [9:0] H_LAST   = 10'(LINE_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(FRAME_LINES - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       toggle;
    logic [9:0] h;
    logic [9:0] v;
    logic       h_last;
    logic       v_last;
    sync_t      sync_raw;
    sync_t      sync_out;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) toggle <= 1'b0;
        else       toggle <= ~toggle;
    end

    assign pix_en     = toggle;
    assign VGA_CLK    = toggle;
    assign VGA_SYNC_N = 1'b0;

    // >= rather than == so a corrupted count still wraps on the next pixel.
    assign h_last = (h >= H_LAST);
    assign v_last = (v >= V_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            h            <= '0;
            v            <= '0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            frame_start  <= pix_en && h_last && v_last;
            vblank_start <= pix_en && h_last && (v == V_VIS_LAST);
            if (pix_en) begin
                if (h_last) begin
                    h <= '0;
                    if (v_last) v <= '0;
                    else        v <= v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    always_comb begin
        sync_raw         = SYNC_IDLE;
        sync_raw.hs      = !in_window(h, HS_START, HS_END);
        sync_raw.vs      = !in_window(v, VS_START, VS_END);
        sync_raw.blank_n = (h < H_VIS) && (v < V_VIS);
    end

    sync_delay #(.DEPTH(STAGES)) u_sync_delay (
        .clk (Clk),
        .rst (Reset),
        .en  (pix_en),
        .d   (sync_raw),
        .q   (sync_out)
    );

    assign VGA_HS      = sync_out.hs;
    assign VGA_VS      = sync_out.vs;
    assign VGA_BLANK_N = sync_out.blank_n;
    assign DrawX       = h;
    assign DrawY       = v;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: one full-size instance plus four reduced-timing instances across delay depths, checked against an arithmetic scan model.
module tb_vga_scan_gen;

    typedef struct packed {
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       sync_n;
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       fs;
        logic       vbs;
    } obs_t;

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       hs;
        logic       bl;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       vclk [5];
    logic       hs   [5];
    logic       vs   [5];
    logic       bl   [5];
    logic       sn   [5];
    logic [9:0] dx   [5];
    logic [9:0] dy   [5];
    logic       pe   [5];
    logic       fs   [5];
    logic       vbs  [5];

    int checks = 0;
    int errors = 0;
    int n = 0;

    always #10 Clk = ~Clk;

    vga_scan_gen u_def (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(vclk[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
        .VGA_BLANK_N(bl[0]), .VGA_SYNC_N(sn[0]), .DrawX(dx[0]), .DrawY(dy[0]),
        .pix_en(pe[0]), .frame_start(fs[0]), .vblank_start(vbs[0]));

    vga_scan_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .PIPE_DLY(0)) u_s0 (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(vclk[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
        .VGA_BLANK_N(bl[1]), .VGA_SYNC_N(sn[1]), .DrawX(dx[1]), .DrawY(dy[1]),
        .pix_en(pe[1]), .frame_start(fs[1]), .vblank_start(vbs[1]));

    vga_scan_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .PIPE_DLY(1)) u_s1 (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(vclk[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]),
        .VGA_BLANK_N(bl[2]), .VGA_SYNC_N(sn[2]), .DrawX(dx[2]), .DrawY(dy[2]),
        .pix_en(pe[2]), .frame_start(fs[2]), .vblank_start(vbs[2]));

    vga_scan_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .PIPE_DLY(2)) u_s2 (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(vclk[3]), .VGA_HS(hs[3]), .VGA_VS(vs[3]),
        .VGA_BLANK_N(bl[3]), .VGA_SYNC_N(sn[3]), .DrawX(dx[3]), .DrawY(dy[3]),
        .pix_en(pe[3]), .frame_start(fs[3]), .vblank_start(vbs[3]));

    vga_scan_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .PIPE_DLY(4)) u_s4 (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(vclk[4]), .VGA_HS(hs[4]), .VGA_VS(vs[4]),
        .VGA_BLANK_N(bl[4]), .VGA_SYNC_N(sn[4]), .DrawX(dx[4]), .DrawY(dy[4]),
        .pix_en(pe[4]), .frame_start(fs[4]), .vblank_start(vbs[4]));

    function automatic int dly_of(int i);
        case (i)
            1:       return 0;
            3:       return 2;
            4:       return 4;
            default: return 1;
        endcase
    endfunction

    // Expected outputs n Clk edges after reset release, from pixel arithmetic alone.
    function automatic obs_t model(int nn, int i);
        int ha, hf, hw, hb, va, vf, vw, vb, ht, vt, p, d, q, hq, vq;
        obs_t e;
        if (i == 0) begin
            ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
        end else begin
            ha = 16; hf = 4; hw = 6; hb = 6; va = 8; vf = 2; vw = 2; vb = 3;
        end
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        p  = nn / 2;
        d  = (dly_of(i) < 1) ? 1 : dly_of(i);
        e.vclk   = (nn % 2 == 1);
        e.pe     = (nn % 2 == 1);
        e.sync_n = 1'b0;
        e.x      = 10'(p % ht);
        e.y      = 10'((p / ht) % vt);
        if (p < d) begin
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
        end else begin
            q  = p - d;
            hq = q % ht;
            vq = (q / ht) % vt;
            e.hs = !(hq >= ha + hf && hq < ha + hf + hw);
            e.vs = !(vq >= va + vf && vq < va + vf + vw);
            e.bl = (hq < ha) && (vq < va);
        end
        e.fs  = (nn % 2 == 0) && (p > 0) && (p % (ht * vt) == 0);
        e.vbs = (nn % 2 == 0) && (p > 0) && (p % ht == 0) && ((p / ht) % vt == va);
        return e;
    endfunction

    function automatic obs_t observe(int i);
        obs_t o;
        o.vclk = vclk[i]; o.hs = hs[i]; o.vs = vs[i]; o.bl = bl[i]; o.sync_n = sn[i];
        o.x = dx[i]; o.y = dy[i]; o.pe = pe[i]; o.fs = fs[i]; o.vbs = vbs[i];
        return o;
    endfunction

    task automatic check_all();
        obs_t got, exp_o;
        for (int i = 0; i < 5; i++) begin
            got   = observe(i);
            exp_o = model(n, i);
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL lockstep inst%0d n=%0d got %h expected %h", i, n, got, exp_o);
            end
        end
    endtask

    // Trackers for the multi-cycle line/frame measurements.
    bit track = 1'b0;
    int hs_low0 = 0, bl_hi0 = 0;
    int hs_low_s [5];
    int fall_x   [5];
    bit hs_prev  [5];
    int fs_q[$], vbs_q[$];
    int fs_x0 = -1, fs_y0 = -1;
    int vs_low = 0, vs_fall_x = -1, vs_fall_y = -1;
    bit vs_prev = 1'b1;

    task automatic step();
        @(posedge Clk);
        n++;
        @(negedge Clk);
        check_all();
        if (track) begin
            if (n <= 1600) begin
                if (!hs[0]) hs_low0++;
                if (bl[0])  bl_hi0++;
            end
            for (int i = 0; i < 5; i++) begin
                if (i > 0 && n < 64 && !hs[i]) hs_low_s[i]++;
                if (!hs[i] && hs_prev[i] && fall_x[i] < 0) fall_x[i] = int'(dx[i]);
                hs_prev[i] = hs[i];
            end
            if (fs[2]) begin
                fs_q.push_back(n);
                if (fs_x0 < 0) begin fs_x0 = int'(dx[2]); fs_y0 = int'(dy[2]); end
            end
            if (vbs[2]) vbs_q.push_back(n);
            if (n < 960 && !vs[2]) vs_low++;
            if (!vs[2] && vs_prev && vs_fall_x < 0) begin
                vs_fall_x = int'(dx[2]); vs_fall_y = int'(dy[2]);
            end
            vs_prev = vs[2];
        end
    endtask

    task automatic pulse_reset(int len, int off_on, int off_off);
        @(negedge Clk);
        #(off_on);
        Reset = 1'b1;
        n = 0;
        #1;
        check_all();
        for (int k = 0; k < len; k++) begin
            @(negedge Clk);
            check_all();
        end
        #(off_off);
        Reset = 1'b0;
    endtask

    task automatic cmp(string name, int got, int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    vec_t tbl [14];
    obs_t o;
    int   guard;
    int   spurious;

    initial begin
        // Full-size instance, PIPE_DLY = 1: n, DrawX, DrawY, pix_en, HS, BLANK_N
        tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{2,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{4,    10'd2,   10'd0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1280, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1282, 10'd641, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1314, 10'd657, 10'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1504, 10'd752, 10'd0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1506, 10'd753, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1600, 10'd0,   10'd1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1601, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1602, 10'd1,   10'd1, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 5; i++) begin
            hs_low_s[i] = 0; fall_x[i] = -1; hs_prev[i] = 1'b1;
        end

        repeat (3) @(negedge Clk);
        check_all();
        #3 Reset = 1'b0;
        track = 1'b1;

        for (int r = 0; r < 14; r++) begin
            while (n < tbl[r].n) step();
            checks++;
            if (dx[0] !== tbl[r].x || dy[0] !== tbl[r].y || pe[0] !== tbl[r].pe ||
                hs[0] !== tbl[r].hs || bl[0] !== tbl[r].bl) begin
                errors++;
                $display("FAIL vec%0d n=%0d got x=%0d y=%0d pe=%b hs=%b bl=%b required x=%0d y=%0d pe=%b hs=%b bl=%b",
                         r, n, dx[0], dy[0], pe[0], hs[0], bl[0],
                         tbl[r].x, tbl[r].y, tbl[r].pe, tbl[r].hs, tbl[r].bl);
            end
        end

        while (n < 2100) step();
        track = 1'b0;

        cmp("hs_low_clk_full", hs_low0, 192);
        cmp("blank_high_clk_full", bl_hi0, 1280);
        cmp("hs_fall_x_full", fall_x[0], 657);
        for (int i = 1; i < 5; i++) begin
            cmp($sformatf("hs_low_clk_dly%0d", dly_of(i)), hs_low_s[i], 12);
            cmp($sformatf("hs_fall_x_dly%0d", dly_of(i)), fall_x[i],
                20 + ((dly_of(i) < 1) ? 1 : dly_of(i)));
        end
        cmp("frame_start_count", fs_q.size(), 2);
        if (fs_q.size() == 2) begin
            cmp("frame_start_first_n", fs_q[0], 960);
            cmp("frame_start_period", fs_q[1] - fs_q[0], 960);
        end
        cmp("frame_start_x", fs_x0, 0);
        cmp("frame_start_y", fs_y0, 0);
        cmp("vblank_count", vbs_q.size(), 2);
        if (vbs_q.size() == 2 && fs_q.size() == 2)
            cmp("vblank_after_frame", vbs_q[1] - fs_q[0], 512);
        cmp("vs_low_clk", vs_low, 128);
        cmp("vs_fall_y", vs_fall_y, 10);
        cmp("vs_fall_x", vs_fall_x, 1);

        // Mid-line reset on the full-size instance.
        guard = 0;
        while (dx[0] != 10'd300 && guard < 4000) begin
            step();
            guard++;
        end
        cmp("reach_x300", int'(dx[0]), 300);
        pulse_reset(3, 3, 3);
        spurious = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            for (int i = 0; i < 5; i++) if (fs[i]) spurious++;
        end
        cmp("no_frame_start_after_reset", spurious, 0);
        o = observe(0);
        cmp("restart_x", int'(o.x), 50);

        // Random run lengths and asynchronous reset pulses.
        for (int it = 0; it < 8; it++) begin
            guard = $urandom_range(4000, 20);
            for (int k = 0; k < guard; k++) step();
            pulse_reset($urandom_range(4, 1), $urandom_range(8, 1), $urandom_range(8, 1));
        end
        repeat (200) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
